// File: rtl/sim_run_monitor.sv
// Observe-only run-control monitor: halt-address matching, cycle watchdog and a
// first-word-fall-through trace of load/store traffic inside an address window.
module sim_run_monitor #(
  parameter int unsigned                 XLEN           = 32,
  parameter int unsigned                 NUM_HALT       = 4,
  parameter logic [NUM_HALT*XLEN-1:0]    HALT_ADDRS     = {4{32'h0000009c}},
  parameter logic [63:0]                 TIMEOUT_CYCLES = 64'd400000000,
  parameter int unsigned                 TRACE_DEPTH    = 16,
  parameter logic [XLEN-1:0]             TRACE_MASK     = 32'hFFF00000,
  parameter logic [XLEN-1:0]             TRACE_MATCH    = 32'h00100000,
  localparam int unsigned                IW             = (NUM_HALT > 1) ? $clog2(NUM_HALT) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [XLEN-1:0] PC,
  input  logic            PC_VALID,
  input  logic            DMWE,
  input  logic            DMRE,
  input  logic [XLEN-1:0] DADDR,
  input  logic [XLEN-1:0] WDATA,
  input  logic [XLEN-1:0] RDATA,
  output logic [1:0]      STATE,
  output logic            DONE,
  output logic [IW-1:0]   HALT_IDX,
  output logic [63:0]     CYCLE_CNT,
  input  logic            TR_RE,
  output logic            TR_VALID,
  output logic            TR_IS_ST,
  output logic [XLEN-1:0] TR_ADDR,
  output logic [XLEN-1:0] TR_DATA,
  output logic            TR_FULL,
  output logic [15:0]     TR_DROP
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int unsigned    PW      = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int unsigned    CW      = $clog2(TRACE_DEPTH) + 1;
  localparam int unsigned    EW      = 2 * XLEN + 1;
  localparam logic [63:0]    TO_LAST = TIMEOUT_CYCLES - 64'd1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(TRACE_DEPTH);

  state_e          state_q;
  logic            done_q;
  logic [IW-1:0]   halt_idx_q;
  logic [63:0]     cycle_q;

  logic [EW-1:0]   mem_q [TRACE_DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     drop_q, drop_d;
  logic            valid_q;
  logic            full_q;

  logic            halt_hit_s;
  logic [IW-1:0]   halt_sel_s;
  logic            timeout_hit_s;
  logic            in_run_s;
  logic            cap_s;
  logic            pop_s;
  logic            push_s;
  logic            drop_s;
  logic [EW-1:0]   entry_s;
  logic [EW-1:0]   head_s;

  // Halt comparators; scanning downward lets the lowest matching index win.
  always_comb begin
    halt_hit_s = 1'b0;
    halt_sel_s = {IW{1'b0}};
    for (int i = NUM_HALT - 1; i >= 0; i--) begin
      if (PC_VALID && (PC == HALT_ADDRS[i*XLEN +: XLEN])) begin
        halt_hit_s = 1'b1;
        halt_sel_s = IW'(i);
      end else begin
        halt_hit_s = halt_hit_s;
      end
    end
    timeout_hit_s = (TIMEOUT_CYCLES != 64'd0) && (cycle_q == TO_LAST);
  end

  // Run-control FSM; a halt outranks a timeout on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      halt_idx_q <= {IW{1'b0}};
      cycle_q    <= 64'd0;
    end else if (START) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
      cycle_q <= 64'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          cycle_q <= cycle_q + 64'd1;
          if (halt_hit_s) begin
            state_q    <= ST_HALTED;
            done_q     <= 1'b1;
            halt_idx_q <= halt_sel_s;
          end else if (timeout_hit_s) begin
            state_q <= ST_TIMEOUT;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  // Capture qualification; a combined read/write records only the store.
  always_comb begin
    in_run_s = (state_q == ST_RUN) && !START;
    cap_s    = in_run_s && ((DADDR & TRACE_MASK) == TRACE_MATCH) && (DMWE || DMRE);
    if (DMWE) begin
      entry_s = {1'b1, DADDR, WDATA};
    end else begin
      entry_s = {1'b0, DADDR, RDATA};
    end
    pop_s  = TR_RE && valid_q && !START;
    push_s = cap_s && (!full_q || pop_s);
    drop_s = cap_s && full_q && !pop_s;
  end

  // FIFO pointer, occupancy and drop-counter next state; START flushes everything.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (START) begin
      rd_d    = {PW{1'b0}};
      wr_d    = {PW{1'b0}};
      count_d = {CW{1'b0}};
      drop_d  = 16'd0;
    end else begin
      if (pop_s) begin
        rd_d = rd_q + PW'(1'b1);
      end else begin
        rd_d = rd_q;
      end
      if (push_s) begin
        wr_d = wr_q + PW'(1'b1);
      end else begin
        wr_d = wr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
      if (drop_s && (drop_q != 16'hFFFF)) begin
        drop_d = drop_q + 16'd1;
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // FIFO control registers; valid/full are registered from the next occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_q    <= {PW{1'b0}};
      wr_q    <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      drop_q  <= 16'd0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      valid_q <= (count_d != {CW{1'b0}});
      full_q  <= (count_d == DEPTH_C);
    end
  end

  // Trace storage; contents are only observable through the valid-gated head.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wr_q] <= entry_s;
    end
  end

  assign head_s    = mem_q[rd_q];
  assign STATE     = state_q;
  assign DONE      = done_q;
  assign HALT_IDX  = halt_idx_q;
  assign CYCLE_CNT = cycle_q;
  assign TR_VALID  = valid_q;
  assign TR_FULL   = full_q;
  assign TR_DROP   = drop_q;
  assign TR_IS_ST  = valid_q & head_s[EW-1];
  assign TR_ADDR   = valid_q ? head_s[2*XLEN-1:XLEN] : {XLEN{1'b0}};
  assign TR_DATA   = valid_q ? head_s[XLEN-1:0]      : {XLEN{1'b0}};

endmodule

// File: tb/tb_sim_run_monitor.sv
// Bench for sim_run_monitor: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model of the run/trace rules.
module tb_sim_run_monitor;

  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] TO    = 64'd64;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [31:0] PC;
  logic        PC_VALID;
  logic        DMWE;
  logic        DMRE;
  logic [31:0] DADDR;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic [1:0]  STATE;
  logic        DONE;
  logic [1:0]  HALT_IDX;
  logic [63:0] CYCLE_CNT;
  logic        TR_RE;
  logic        TR_VALID;
  logic        TR_IS_ST;
  logic [31:0] TR_ADDR;
  logic [31:0] TR_DATA;
  logic        TR_FULL;
  logic [15:0] TR_DROP;

  sim_run_monitor #(
    .XLEN          (32),
    .NUM_HALT      (4),
    .HALT_ADDRS    ({32'h00000200, 32'h00000100, 32'h00000100, 32'h0000009c}),
    .TIMEOUT_CYCLES(TO),
    .TRACE_DEPTH   (DEPTH),
    .TRACE_MASK    (32'hFFF00000),
    .TRACE_MATCH   (32'h00100000)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .PC(PC), .PC_VALID(PC_VALID),
    .DMWE(DMWE), .DMRE(DMRE), .DADDR(DADDR), .WDATA(WDATA), .RDATA(RDATA),
    .STATE(STATE), .DONE(DONE), .HALT_IDX(HALT_IDX), .CYCLE_CNT(CYCLE_CNT),
    .TR_RE(TR_RE), .TR_VALID(TR_VALID), .TR_IS_ST(TR_IS_ST), .TR_ADDR(TR_ADDR),
    .TR_DATA(TR_DATA), .TR_FULL(TR_FULL), .TR_DROP(TR_DROP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    bit        st;
    bit [31:0] a;
    bit [31:0] d;
  } tr_t;

  int              n_checks = 0;
  int              n_fail   = 0;
  bit [31:0]       halt_tbl [4] = '{32'h9c, 32'h100, 32'h100, 32'h200};
  int              m_st;
  int              m_idx;
  longint unsigned m_cnt;
  int              m_drop;
  tr_t             mq [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_cnt = 0; m_drop = 0;
    mq.delete();
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit  pop;
    bit  full;
    bit  cap;
    bit  found;
    tr_t e;
    pop  = TR_RE && (mq.size() > 0);
    full = (mq.size() == DEPTH);
    cap  = 1'b0;
    if (START) begin
      m_st = 1; m_cnt = 0; m_drop = 0;
      mq.delete();
    end else begin
      if (m_st == 1) begin
        cap   = ((DADDR & 32'hFFF00000) == 32'h00100000) && (DMWE || DMRE);
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (!found && PC_VALID && PC == halt_tbl[i]) begin
            found = 1'b1;
            m_idx = i;
          end
        end
        if (found) m_st = 2;
        else if (m_cnt == TO - 1) m_st = 3;
        m_cnt = m_cnt + 1;
      end
      if (pop) void'(mq.pop_front());
      if (cap) begin
        e.st = DMWE;
        e.a  = DADDR;
        e.d  = DMWE ? WDATA : RDATA;
        if (full && !pop) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic compare_all();
    tr_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    check_eq("STATE",     64'(STATE),     64'(m_st));
    check_eq("DONE",      64'(DONE),      64'(m_st >= 2));
    check_eq("HALT_IDX",  64'(HALT_IDX),  64'(m_idx));
    check_eq("CYCLE_CNT", CYCLE_CNT,      m_cnt);
    check_eq("TR_VALID",  64'(TR_VALID),  64'(mq.size() > 0));
    check_eq("TR_FULL",   64'(TR_FULL),   64'(mq.size() == DEPTH));
    check_eq("TR_DROP",   64'(TR_DROP),   64'(m_drop));
    check_eq("TR_IS_ST",  64'(TR_IS_ST),  64'(h.st));
    check_eq("TR_ADDR",   64'(TR_ADDR),   64'(h.a));
    check_eq("TR_DATA",   64'(TR_DATA),   64'(h.d));
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (!RST) model_step();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    START = 1'b0; PC_VALID = 1'b0; DMWE = 1'b0; DMRE = 1'b0; TR_RE = 1'b0;
  endtask

  task automatic do_start();
    quiet();
    START = 1'b1;
    cycle();
    START = 1'b0;
  endtask

  task automatic store(input logic [31:0] a);
    DMWE = 1'b1; DADDR = a; WDATA = $urandom;
    cycle();
    DMWE = 1'b0;
  endtask

  initial begin
    int sel;
    quiet();
    PC = 32'd0; DADDR = 32'd0; WDATA = 32'd0; RDATA = 32'd0;
    RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    compare_all();
    check_eq("rst_state", 64'(STATE), 64'd0);
    RST = 1'b0;

    // Sequential PCs up to the first halt address.
    do_start();
    for (int k = 0; k < 40; k++) begin
      PC = 32'(4 * k); PC_VALID = 1'b1;
      cycle();
    end
    PC_VALID = 1'b0;
    check_eq("t1_state", 64'(STATE), 64'd2);
    check_eq("t1_cnt", CYCLE_CNT, 64'd40);
    check_eq("t1_idx", 64'(HALT_IDX), 64'd0);

    // Lowest matching comparator, and PC_VALID gating.
    do_start();
    PC = 32'h100; PC_VALID = 1'b0;
    cycle();
    check_eq("t2_novalid", 64'(STATE), 64'd1);
    PC_VALID = 1'b1;
    cycle();
    check_eq("t2_idx", 64'(HALT_IDX), 64'd1);
    check_eq("t2_done", 64'(DONE), 64'd1);

    // Watchdog expiry, then halt and timeout on the same edge.
    do_start();
    PC = 32'h4; PC_VALID = 1'b1;
    repeat (64) cycle();
    check_eq("t3_timeout", 64'(STATE), 64'd3);
    check_eq("t3_cnt", CYCLE_CNT, 64'd64);
    do_start();
    PC = 32'h4; PC_VALID = 1'b1;
    repeat (63) cycle();
    PC = 32'h200;
    cycle();
    check_eq("t4_halt_wins", 64'(STATE), 64'd2);
    check_eq("t4_idx", 64'(HALT_IDX), 64'd3);

    // Overflow, in-order drain, out-of-window store.
    do_start();
    for (int k = 0; k < 5; k++) store(32'h00100000 + 32'(4 * k));
    check_eq("t5_full", 64'(TR_FULL), 64'd1);
    check_eq("t5_drop", 64'(TR_DROP), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check_eq("t5_pop_addr", 64'(TR_ADDR), 64'(32'h00100000 + 32'(4 * k)));
      check_eq("t5_pop_st", 64'(TR_IS_ST), 64'd1);
      TR_RE = 1'b1;
      cycle();
      TR_RE = 1'b0;
    end
    check_eq("t5_empty", 64'(TR_VALID), 64'd0);
    store(32'h00200000);
    check_eq("t5_outside", 64'(TR_VALID), 64'd0);

    // Push and pop together while full.
    for (int k = 0; k < 4; k++) store(32'h00100100 + 32'(4 * k));
    TR_RE = 1'b1;
    store(32'h00100200);
    TR_RE = 1'b0;
    check_eq("t6_full", 64'(TR_FULL), 64'd1);
    check_eq("t6_drop", 64'(TR_DROP), 64'd1);

    // Combined read and write records one store.
    do_start();
    DMWE = 1'b1; DMRE = 1'b1; DADDR = 32'h00100040; WDATA = 32'hA5A5A5A5; RDATA = 32'h5A5A5A5A;
    cycle();
    quiet();
    check_eq("t7_st", 64'(TR_IS_ST), 64'd1);
    check_eq("t7_data", 64'(TR_DATA), 64'hA5A5A5A5);
    TR_RE = 1'b1;
    cycle();
    TR_RE = 1'b0;
    check_eq("t7_single", 64'(TR_VALID), 64'd0);

    // Asynchronous reset in the middle of a run.
    do_start();
    for (int k = 0; k < 3; k++) store(32'h00100010 + 32'(4 * k));
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_eq("t8_state", 64'(STATE), 64'd0);
    check_eq("t8_valid", 64'(TR_VALID), 64'd0);
    check_eq("t8_cnt", CYCLE_CNT, 64'd0);
    compare_all();
    RST = 1'b0;
    cycle();

    // Capture on the halt edge, then restart from HALTED.
    do_start();
    store(32'h00100000);
    store(32'h00100004);
    PC = 32'h9c; PC_VALID = 1'b1;
    store(32'h00100008);
    PC_VALID = 1'b0;
    check_eq("t9_state", 64'(STATE), 64'd2);
    check_eq("t9_addr", 64'(TR_ADDR), 64'h00100000);
    cycle();
    do_start();
    check_eq("t9_flush", 64'(TR_VALID), 64'd0);
    check_eq("t9_cnt", CYCLE_CNT, 64'd0);
    cycle();
    check_eq("t9_cnt1", CYCLE_CNT, 64'd1);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      quiet();
      if ($urandom_range(0, 39) == 0) begin
        START = 1'b1;
      end else begin
        sel = $urandom_range(0, 29);
        PC = (sel == 0) ? 32'h9c : (sel == 1) ? 32'h100 : (sel == 2) ? 32'h200 : ($urandom & 32'h0000FFFC);
        PC_VALID = ($urandom_range(0, 1) == 1);
        DMWE = ($urandom_range(0, 1) == 1);
        DMRE = ($urandom_range(0, 1) == 1);
        DADDR = ($urandom_range(0, 3) != 0) ? (32'h00100000 | ($urandom & 32'h000FFFFC)) : $urandom;
        WDATA = $urandom;
        RDATA = $urandom;
        TR_RE = ($urandom_range(0, 3) == 0);
      end
      cycle();
    end
    quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
